// File: rtl/dual_port_ram_pkg.sv
// Shared constants and state type for the dual-port instruction/data RAM.
// Default geometry matches the Beta core's instruction word layout.
package dual_port_ram_pkg;

  localparam int DEF_DWIDTH    = 32;
  localparam int DEF_AWIDTH    = 10;
  localparam int DEF_MEMDEPTH  = 1024;
  localparam int DEF_INIT_MODE = 1;

  typedef enum logic {
    RAM_INIT = 1'b0,
    RAM_RUN  = 1'b1
  } ram_state_t;

  // Number of byte lanes in a word of the given width.
  function automatic int byte_lanes(input int dwidth);
    return dwidth / 8;
  endfunction

endpackage

// File: rtl/dual_port_ram_byte_lane.sv
// One 8-bit slice of the RAM: a single write port and two independently
// enabled read ports with registered outputs.
module dual_port_ram_byte_lane #(
  parameter int AWIDTH   = 10,
  parameter int MEMDEPTH = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic              a_en,
  input  logic              a_zero,
  input  logic              a_fwd,
  input  logic [AWIDTH-1:0] a_addr,
  input  logic              b_en,
  input  logic              b_zero,
  input  logic [AWIDTH-1:0] b_addr,
  output logic [7:0]        a_q,
  output logic [7:0]        b_q
);

  logic [7:0] mem [MEMDEPTH];

  // Storage write; the caller only raises we for in-range addresses.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Port A read register; a_fwd selects the byte being written this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= 8'h00;
    end else if (a_en) begin
      if (a_zero) begin
        a_q <= 8'h00;
      end else if (a_fwd) begin
        a_q <= wdata;
      end else begin
        a_q <= mem[a_addr];
      end
    end
  end

  // Port B read register; write acks and out-of-range reads return zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_q <= 8'h00;
    end else if (b_en) begin
      if (b_zero) begin
        b_q <= 8'h00;
      end else begin
        b_q <= mem[b_addr];
      end
    end
  end

endmodule

// File: rtl/dual_port_ram.sv
// Instruction (read-only) + data (byte-enabled R/W) RAM with a hardware init sweep.
// Define RAM_BYPASS_EN to forward same-cycle D-write data to the I-port; otherwise read-first.
module dual_port_ram
  import dual_port_ram_pkg::*;
#(
  parameter int DWIDTH    = DEF_DWIDTH,
  parameter int AWIDTH    = DEF_AWIDTH,
  parameter int MEMDEPTH  = DEF_MEMDEPTH,
  parameter int INIT_MODE = DEF_INIT_MODE
) (
  input  logic                clk,
  input  logic                reset,
  output logic                init_busy,
  input  logic                i_req,
  input  logic [AWIDTH-1:0]   i_addr,
  output logic                i_valid,
  output logic [DWIDTH-1:0]   i_data,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DWIDTH/8-1:0] d_be,
  input  logic [AWIDTH-1:0]   d_addr,
  input  logic [DWIDTH-1:0]   d_wdata,
  output logic                d_valid,
  output logic [DWIDTH-1:0]   d_rdata,
  output logic                d_err
);

  localparam int                NBYTES    = byte_lanes(DWIDTH);
  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(MEMDEPTH - 1);
  localparam logic [AWIDTH:0]   DEPTH_EXT = (AWIDTH + 1)'(MEMDEPTH);

  ram_state_t          state;
  ram_state_t          next_state;
  logic [AWIDTH-1:0]   sweep_cnt;
  logic [AWIDTH-1:0]   sweep_next;

  logic                run;
  logic                i_acc;
  logic                d_acc;
  logic                i_oor;
  logic                d_oor;
  logic [AWIDTH-1:0]   waddr;
  logic [DWIDTH-1:0]   wdata;
  logic [DWIDTH-1:0]   init_word;
  logic [NBYTES-1:0]   we_lane;
  logic [NBYTES-1:0]   fwd_lane;

  // State, sweep counter and init_busy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RAM_INIT;
      sweep_cnt <= {AWIDTH{1'b0}};
      init_busy <= 1'b1;
    end else begin
      state     <= next_state;
      sweep_cnt <= sweep_next;
      init_busy <= (next_state == RAM_INIT);
    end
  end

  // Next-state logic: one word per cycle, leave INIT after the last word.
  always_comb begin
    next_state = state;
    sweep_next = sweep_cnt;
    case (state)
      RAM_INIT: begin
        if (sweep_cnt == LAST_ADDR) begin
          next_state = RAM_RUN;
          sweep_next = {AWIDTH{1'b0}};
        end else begin
          next_state = RAM_INIT;
          sweep_next = sweep_cnt + AWIDTH'(1);
        end
      end
      RAM_RUN: begin
        next_state = RAM_RUN;
        sweep_next = sweep_cnt;
      end
      default: begin
        next_state = RAM_INIT;
        sweep_next = {AWIDTH{1'b0}};
      end
    endcase
  end

  // Output logic: request acceptance, range checks and the shared write port mux.
  always_comb begin
    run       = (state == RAM_RUN);
    i_acc     = i_req & run;
    d_acc     = d_req & run;
    i_oor     = ({1'b0, i_addr} >= DEPTH_EXT);
    d_oor     = ({1'b0, d_addr} >= DEPTH_EXT);
    init_word = (INIT_MODE == 1) ? DWIDTH'(sweep_cnt) : {DWIDTH{1'b0}};
    if (run) begin
      waddr = d_addr;
      wdata = d_wdata;
      if (d_acc && d_we && !d_oor) begin
        we_lane = d_be;
      end else begin
        we_lane = {NBYTES{1'b0}};
      end
    end else begin
      waddr   = sweep_cnt;
      wdata   = init_word;
      we_lane = {NBYTES{1'b1}};
    end
    fwd_lane = {NBYTES{1'b0}};
`ifdef RAM_BYPASS_EN
    // Only lanes actually written are forwarded; the rest read the old word.
    if (i_acc && (i_addr == d_addr)) begin
      fwd_lane = we_lane;
    end else begin
      fwd_lane = {NBYTES{1'b0}};
    end
`endif
  end

  // Response handshake registers; reset drops anything in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      d_err   <= 1'b0;
    end else begin
      i_valid <= i_acc;
      d_valid <= d_acc;
      d_err   <= d_acc & d_oor;
    end
  end

  for (genvar k = 0; k < NBYTES; k++) begin : g_lane
    dual_port_ram_byte_lane #(
      .AWIDTH   (AWIDTH),
      .MEMDEPTH (MEMDEPTH)
    ) u_lane (
      .clk    (clk),
      .rst    (reset),
      .we     (we_lane[k]),
      .waddr  (waddr),
      .wdata  (wdata[8*k +: 8]),
      .a_en   (i_acc),
      .a_zero (i_oor),
      .a_fwd  (fwd_lane[k]),
      .a_addr (i_addr),
      .b_en   (d_acc),
      .b_zero (d_we | d_oor),
      .b_addr (d_addr),
      .a_q    (i_data[8*k +: 8]),
      .b_q    (d_rdata[8*k +: 8])
    );
  end

endmodule

// File: tb/tb_dual_port_ram.sv
// Directed + randomized bench for dual_port_ram (MEMDEPTH=1000) against a word-array model.
module tb_dual_port_ram;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 1000;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          init_busy;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_valid;
  logic [DW-1:0] i_data;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [3:0]    d_be = 4'h0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_valid;
  logic [DW-1:0] d_rdata;
  logic          d_err;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] model [DEPTH];

  dual_port_ram #(
    .DWIDTH(DW), .AWIDTH(AW), .MEMDEPTH(DEPTH), .INIT_MODE(1)
  ) dut (
    .clk(clk), .reset(reset), .init_busy(init_busy),
    .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid), .i_data(i_data),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_init();
    for (int i = 0; i < DEPTH; i++) model[i] = i;
  endtask

  // One request cycle: predict from the model, apply, check responses after the edge.
  task automatic step(input string tag, input bit ir, input int ia, input bit dr, input bit dw,
                      input logic [3:0] be, input int da, input logic [31:0] wd);
    logic [31:0] exp_i, exp_d, merged;
    bit exp_err;
    exp_i = 32'h0;
    exp_d = 32'h0;
    exp_err = dr && (da >= DEPTH);
    if (ir && ia < DEPTH) exp_i = model[ia];
    if (dr && !dw && da < DEPTH) exp_d = model[da];
    if (dr && dw && da < DEPTH) begin
      merged = model[da];
      for (int k = 0; k < 4; k++) if (be[k]) merged[8*k +: 8] = wd[8*k +: 8];
`ifdef RAM_BYPASS_EN
      if (ir && ia == da) exp_i = merged;
`endif
      model[da] = merged;
    end
    i_req = ir; i_addr = ia[AW-1:0];
    d_req = dr; d_we = dw; d_be = be; d_addr = da[AW-1:0]; d_wdata = wd;
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0;
    check({tag, "_ivalid"}, {31'b0, i_valid}, {31'b0, ir});
    if (ir) check({tag, "_idata"}, i_data, exp_i);
    check({tag, "_dvalid"}, {31'b0, d_valid}, {31'b0, dr});
    if (dr) begin
      check({tag, "_drdata"}, d_rdata, exp_d);
      check({tag, "_derr"}, {31'b0, d_err}, {31'b0, exp_err});
    end
  endtask

  // Count init_busy cycles while hammering both ports; no response may appear.
  task automatic wait_init(input string tag);
    int cnt;
    bit saw_valid;
    cnt = 0;
    saw_valid = 1'b0;
    while (init_busy === 1'b1 && cnt < 2000) begin
      i_req = 1'b1; i_addr = AW'($urandom_range(0, 1023));
      d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_be = 4'hF;
      d_addr = AW'($urandom_range(0, 1023)); d_wdata = $urandom;
      @(posedge clk); #1;
      cnt++;
      if (i_valid !== 1'b0 || d_valid !== 1'b0) saw_valid = 1'b1;
    end
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    check({tag, "_busy_cycles"}, cnt, DEPTH);
    check({tag, "_no_valid_in_init"}, {31'b0, saw_valid}, 32'h0);
  endtask

  initial begin
    #2 reset = 1'b1;
    #10;
    check("rst_busy", {31'b0, init_busy}, 32'h1);
    check("rst_ivalid", {31'b0, i_valid}, 32'h0);
    check("rst_dvalid", {31'b0, d_valid}, 32'h0);
    check("rst_derr", {31'b0, d_err}, 32'h0);
    check("rst_idata", i_data, 32'h0);
    check("rst_drdata", d_rdata, 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    wait_init("init1");
    model_init();

    step("t1_rd5", 1'b1, 5, 1'b0, 1'b0, 4'h0, 0, 32'h0);
    step("t2_wr3", 1'b0, 0, 1'b1, 1'b1, 4'b0101, 3, 32'hDEADBEEF);
    step("t2_rd3", 1'b0, 0, 1'b1, 1'b0, 4'h0, 3, 32'h0);
    check("t2_const", d_rdata, 32'h00AD00EF);
    step("t3_i0", 1'b1, 0, 1'b0, 1'b0, 4'h0, 0, 32'h0);
    step("t3_i1", 1'b1, 1, 1'b0, 1'b0, 4'h0, 0, 32'h0);
    step("t3_i2", 1'b1, 2, 1'b0, 1'b0, 4'h0, 0, 32'h0);
    step("t4_coll", 1'b1, 7, 1'b1, 1'b1, 4'hF, 7, 32'h12345678);
`ifdef RAM_BYPASS_EN
    check("t4_const", i_data, 32'h12345678);
`else
    check("t4_const", i_data, 32'h00000007);
`endif
    step("t4_after", 1'b1, 7, 1'b0, 1'b0, 4'h0, 0, 32'h0);
    step("t5_rd1000", 1'b1, 1000, 1'b1, 1'b0, 4'h0, 1000, 32'h0);
    step("t5_wr1000", 1'b0, 0, 1'b1, 1'b1, 4'hF, 1000, 32'hCAFEF00D);
    step("t5_rd1000b", 1'b0, 0, 1'b1, 1'b0, 4'h0, 1000, 32'h0);
    step("t5_rd1023", 1'b1, 1023, 1'b1, 1'b0, 4'h0, 1023, 32'h0);
    step("t5_rd999", 1'b1, 999, 1'b1, 1'b0, 4'h0, 999, 32'h0);
    step("be0_wr", 1'b0, 0, 1'b1, 1'b1, 4'h0, 9, 32'hFFFFFFFF);
    step("be0_rd", 1'b0, 0, 1'b1, 1'b0, 4'h0, 9, 32'h0);

    for (int n = 0; n < 400; n++) begin
      int ia, da;
      ia = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 1023);
      da = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 1023);
      step("rand", 1'($urandom_range(0, 1)), ia, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), da, $urandom);
    end

    // Reset while a response is in flight: it must be dropped.
    i_req = 1'b1; i_addr = 10'd4; d_req = 1'b1; d_we = 1'b0; d_addr = 10'd4;
    @(posedge clk); #1 reset = 1'b1;
    i_req = 1'b0; d_req = 1'b0;
    #1;
    check("drop_ivalid", {31'b0, i_valid}, 32'h0);
    check("drop_dvalid", {31'b0, d_valid}, 32'h0);
    check("drop_busy", {31'b0, init_busy}, 32'h1);
    @(posedge clk); #1 reset = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(posedge clk);
    end
    #1;
    check("mid_busy_500", {31'b0, init_busy}, 32'h1);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    wait_init("init2");
    model_init();
    step("t6_rd3", 1'b1, 3, 1'b1, 1'b0, 4'h0, 3, 32'h0);
    step("t6_rd999", 1'b1, 999, 1'b1, 1'b0, 4'h0, 998, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
